// File: rtl/cycle_sequencer.sv
// cycle_sequencer -- machine-cycle sequencer for the TB4004 core.
//
// Steps an 8-phase index (A1 A2 A3 M1 M2 X1 X2 X3 = 0..7) once per clock,
// latches the instruction nibbles from the ROM bus at M1/M2 and tracks
// two-word instructions so that they execute only in their second cycle.
//
// Build option:
//   SEQ_STOP_EN  defined   -> RUN/STOP halt machine driven by stopReq; the
//                             core halts only at an instruction boundary.
//                undefined -> stopReq ignored, stopAck tied low.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   romData    in   4-bit ROM data nibble, sampled at M1 and M2
//   stopReq    in   halt request (SEQ_STOP_EN only)
//   cycle      out  3-bit phase index
//   sync       out  high during X3
//   opr/opa    out  first-word opcode / operand
//   opr2/opa2  out  second-word upper / lower nibble
//   secondWord out  current cycle fetches the second word
//   pcInc      out  one-clock program-counter advance pulse at A3
//   execValid  out  X1..X3 of the cycle in which the instruction executes
//   stopAck    out  core is halted

module cycle_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] romData,
  input  logic       stopReq,
  output logic [2:0] cycle,
  output logic       sync,
  output logic [3:0] opr,
  output logic [3:0] opa,
  output logic [3:0] opr2,
  output logic [3:0] opa2,
  output logic       secondWord,
  output logic       pcInc,
  output logic       execValid,
  output logic       stopAck
);

  localparam logic [2:0] CycM1 = 3'd3;
  localparam logic [2:0] CycM2 = 3'd4;
  localparam logic [2:0] CycX1 = 3'd5;
  localparam logic [2:0] CycX3 = 3'd7;
  localparam logic [2:0] CycA3 = 3'd2;

  logic [2:0] cycleQ, cycleD;
  logic [3:0] oprQ, oprD;
  logic [3:0] opaQ, opaD;
  logic [3:0] opr2Q, opr2D;
  logic [3:0] opa2Q, opa2D;
  logic       secondWordQ, secondWordD;
  logic       twoWordQ, twoWordD;
  logic       running;

  // JCN, FIM (opa[0]=0), JUN, JMS and ISZ carry a second ROM word.
  function automatic logic isTwoWord(input logic [3:0] code, input logic [3:0] operand);
    case (code)
      4'h1, 4'h4, 4'h5, 4'h7: isTwoWord = 1'b1;
      4'h2:                   isTwoWord = ~operand[0];
      default:                isTwoWord = 1'b0;
    endcase
  endfunction

`ifdef SEQ_STOP_EN
  localparam logic StRun  = 1'b0;
  localparam logic StStop = 1'b1;

  logic stateQ, stateD;

  assign running = (stateQ == StRun);
  assign stopAck = (stateQ == StStop);
`else
  logic unusedStopReq;

  assign unusedStopReq = stopReq;
  assign running       = 1'b1;
  assign stopAck       = 1'b0;
`endif

  always_comb begin
    cycleD      = cycleQ;
    oprD        = oprQ;
    opaD        = opaQ;
    opr2D       = opr2Q;
    opa2D       = opa2Q;
    secondWordD = secondWordQ;
    twoWordD    = twoWordQ;
`ifdef SEQ_STOP_EN
    stateD      = stateQ;
`endif
    if (running) begin
      // X3 wraps to A1; entering STOP therefore also leaves cycle at 0.
      cycleD = cycleQ + 3'd1;
      case (cycleQ)
        CycM1: begin
          if (secondWordQ) opr2D = romData;
          else             oprD  = romData;
        end
        CycM2: begin
          if (secondWordQ) begin
            opa2D = romData;
          end else begin
            opaD     = romData;
            twoWordD = isTwoWord(oprQ, romData);
          end
        end
        CycX3: begin
          secondWordD = twoWordQ & ~secondWordQ;
          if (secondWordQ) twoWordD = 1'b0;
`ifdef SEQ_STOP_EN
          // Never halt between the two words of one instruction.
          if (stopReq && !(twoWordQ & ~secondWordQ)) stateD = StStop;
`endif
        end
        default: ;
      endcase
    end
`ifdef SEQ_STOP_EN
    else if (!stopReq) begin
      // Resume edge: cycle stays 0 here, counting restarts on the next edge.
      stateD = StRun;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycleQ      <= 3'd0;
      oprQ        <= 4'd0;
      opaQ        <= 4'd0;
      opr2Q       <= 4'd0;
      opa2Q       <= 4'd0;
      secondWordQ <= 1'b0;
      twoWordQ    <= 1'b0;
`ifdef SEQ_STOP_EN
      stateQ      <= StRun;
`endif
    end else begin
      cycleQ      <= cycleD;
      oprQ        <= oprD;
      opaQ        <= opaD;
      opr2Q       <= opr2D;
      opa2Q       <= opa2D;
      secondWordQ <= secondWordD;
      twoWordQ    <= twoWordD;
`ifdef SEQ_STOP_EN
      stateQ      <= stateD;
`endif
    end
  end

  assign cycle      = cycleQ;
  assign opr        = oprQ;
  assign opa        = opaQ;
  assign opr2       = opr2Q;
  assign opa2       = opa2Q;
  assign secondWord = secondWordQ;
  assign sync       = running & (cycleQ == CycX3);
  assign pcInc      = running & (cycleQ == CycA3);
  assign execValid  = running & (cycleQ >= CycX1) & (secondWordQ | ~twoWordQ);

endmodule

// File: tb/tb_cycle_sequencer.sv
// Self-checking bench for cycle_sequencer: a behavioural model pushes the
// expected outputs for every driven clock into a queue, which is popped and
// compared once the DUT has taken the edge; directed checks cover the
// scenarios listed for the block.

module tb_cycle_sequencer;

`ifdef SEQ_STOP_EN
  localparam bit StopEn = 1'b1;
`else
  localparam bit StopEn = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] romData;
  logic       stopReq;
  logic [2:0] cycle;
  logic       sync;
  logic [3:0] opr, opa, opr2, opa2;
  logic       secondWord, pcInc, execValid, stopAck;

  cycle_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .romData    (romData),
    .stopReq    (stopReq),
    .cycle      (cycle),
    .sync       (sync),
    .opr        (opr),
    .opa        (opa),
    .opr2       (opr2),
    .opa2       (opa2),
    .secondWord (secondWord),
    .pcInc      (pcInc),
    .execValid  (execValid),
    .stopAck    (stopAck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] cyc;
    logic       sync;
    logic [3:0] opr, opa, opr2, opa2;
    logic       sw, pcInc, exec, ack;
  } expT;

  expT expQ[$];
  int  nCompared   = 0;
  int  nMismatched = 0;

  // Reference model state.
  logic [2:0] mCycle;
  logic [3:0] mOpr, mOpa, mOpr2, mOpa2;
  logic       mSw, mTw, mStop;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic modelTwoWord(input logic [3:0] code, input logic [3:0] operand);
    return (code == 4'h1) || (code == 4'h2 && !operand[0]) || (code == 4'h4) ||
           (code == 4'h5) || (code == 4'h7);
  endfunction

  task automatic modelReset();
    mCycle = 3'd0; mOpr = 4'd0; mOpa = 4'd0; mOpr2 = 4'd0; mOpa2 = 4'd0;
    mSw = 1'b0; mTw = 1'b0; mStop = 1'b0;
  endtask

  task automatic modelStep(input logic [3:0] rd, input logic sr);
    logic nsw;
    if (mStop) begin
      if (!sr) mStop = 1'b0;
    end else begin
      case (mCycle)
        3'd3: if (mSw) mOpr2 = rd; else mOpr = rd;
        3'd4: begin
          if (mSw) mOpa2 = rd;
          else begin
            mOpa = rd;
            mTw  = modelTwoWord(mOpr, rd);
          end
        end
        3'd7: begin
          nsw = mTw & ~mSw;
          if (mSw) mTw = 1'b0;
          if (StopEn && sr && !nsw) mStop = 1'b1;
          mSw = nsw;
        end
        default: ;
      endcase
      mCycle = mCycle + 3'd1;
    end
  endtask

  function automatic expT modelOut();
    expT e;
    e.cyc   = mCycle;
    e.sync  = !mStop && mCycle == 3'd7;
    e.pcInc = !mStop && mCycle == 3'd2;
    e.exec  = !mStop && mCycle >= 3'd5 && (mSw || !mTw);
    e.ack   = mStop;
    e.opr   = mOpr;  e.opa  = mOpa;
    e.opr2  = mOpr2; e.opa2 = mOpa2;
    e.sw    = mSw;
    return e;
  endfunction

  task automatic compareAll();
    expT e;
    if (expQ.size() == 0) begin
      checkEq("queueEmpty", 32'd0, 32'd1);
      return;
    end
    e = expQ.pop_front();
    checkEq("cycle", 32'(cycle), 32'(e.cyc));
    checkEq("sync", 32'(sync), 32'(e.sync));
    checkEq("pcInc", 32'(pcInc), 32'(e.pcInc));
    checkEq("execValid", 32'(execValid), 32'(e.exec));
    checkEq("stopAck", 32'(stopAck), 32'(e.ack));
    checkEq("secondWord", 32'(secondWord), 32'(e.sw));
    checkEq("opr", 32'(opr), 32'(e.opr));
    checkEq("opa", 32'(opa), 32'(e.opa));
    checkEq("opr2", 32'(opr2), 32'(e.opr2));
    checkEq("opa2", 32'(opa2), 32'(e.opa2));
  endtask

  // One clock: drive at the falling edge, check 1 time unit after the rising edge.
  task automatic tick(input logic [3:0] rd, input logic sr);
    @(negedge clk);
    romData = rd;
    stopReq = sr;
    modelStep(rd, sr);
    expQ.push_back(modelOut());
    @(posedge clk);
    #1;
    compareAll();
  endtask

  // Eight clocks with w0 at M1 and w1 at M2, noise on the bus elsewhere.
  task automatic runCycle(input logic [3:0] w0, input logic [3:0] w1, input logic sr,
                          input bit directed, input logic expExec, input logic expSw,
                          input logic [3:0] eOpr, input logic [3:0] eOpa,
                          input logic [3:0] eOpr2, input logic [3:0] eOpa2);
    for (int i = 0; i < 8; i++) begin
      logic [3:0] rd;
      if (mCycle == 3'd3)      rd = w0;
      else if (mCycle == 3'd4) rd = w1;
      else                     rd = 4'($urandom_range(15));
      tick(rd, sr);
      if (directed && mCycle == 3'd5) begin
        checkEq("dirExecX1", 32'(execValid), 32'(expExec));
        checkEq("dirSecondWord", 32'(secondWord), 32'(expSw));
        checkEq("dirOpr", 32'(opr), 32'(eOpr));
        checkEq("dirOpa", 32'(opa), 32'(eOpa));
        checkEq("dirOpr2", 32'(opr2), 32'(eOpr2));
        checkEq("dirOpa2", 32'(opa2), 32'(eOpa2));
      end
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    modelReset();
    expQ.push_back(modelOut());
    #1;
    compareAll();
    checkEq("rstCycle", 32'(cycle), 32'd0);
    checkEq("rstOpr", 32'(opr), 32'd0);
    checkEq("rstSecondWord", 32'(secondWord), 32'd0);
    checkEq("rstExec", 32'(execValid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    expQ.push_back(modelOut());
    compareAll();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    romData = 4'd0;
    stopReq = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
    expQ.push_back(modelOut());
    compareAll();
    checkEq("resetCycle", 32'(cycle), 32'd0);
    checkEq("resetAck", 32'(stopAck), 32'd0);
    rst = 1'b0;

    // Free run: cycle value equals the clock count modulo 8.
    for (int i = 1; i <= 16; i++) begin
      tick(4'd0, 1'b0);
      checkEq("frCycle", 32'(cycle), 32'(i % 8));
      checkEq("frSync", 32'(sync), 32'(i == 7 || i == 15));
      checkEq("frPcInc", 32'(pcInc), 32'(i == 2 || i == 10));
    end

    // ADD 3.
    runCycle(4'h8, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 4'h8, 4'h3, 4'h0, 4'h0);
    // JUN 0x2A5 then a NOP.
    runCycle(4'h4, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 4'h4, 4'h2, 4'h0, 4'h0);
    runCycle(4'hA, 4'h5, 1'b0, 1'b1, 1'b1, 1'b1, 4'h4, 4'h2, 4'hA, 4'h5);
    runCycle(4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'hA, 4'h5);
    // FIM (two words) then SRC (single word).
    runCycle(4'h2, 4'h4, 1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 4'h4, 4'hA, 4'h5);
    runCycle(4'h1, 4'h3, 1'b0, 1'b1, 1'b1, 1'b1, 4'h2, 4'h4, 4'h1, 4'h3);
    runCycle(4'h2, 4'h5, 1'b0, 1'b1, 1'b1, 1'b0, 4'h2, 4'h5, 4'h1, 4'h3);

    // JMS first word interrupted by reset at X2.
    for (int i = 0; i < 6; i++) tick((mCycle == 3'd3) ? 4'h5 : 4'h0, 1'b0);
    checkEq("jmsCycle", 32'(cycle), 32'd6);
    checkEq("jmsExec", 32'(execValid), 32'd0);
    doReset();
    runCycle(4'hD, 4'h7, 1'b0, 1'b1, 1'b1, 1'b0, 4'hD, 4'h7, 4'h0, 4'h0);

    // JCN with stopReq raised during its first word.
    runCycle(4'h1, 4'h2, 1'b1, 1'b1, 1'b0, 1'b0, 4'h1, 4'h2, 4'h0, 4'h0);
    runCycle(4'h3, 4'h4, 1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4);
`ifdef SEQ_STOP_EN
    checkEq("stopAckSet", 32'(stopAck), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick(4'h0, 1'b1);
      checkEq("stopCycle", 32'(cycle), 32'd0);
      checkEq("stopPcInc", 32'(pcInc), 32'd0);
      checkEq("stopAckHeld", 32'(stopAck), 32'd1);
    end
    tick(4'h0, 1'b0);
    checkEq("resumeAck", 32'(stopAck), 32'd0);
    checkEq("resumeCycle0", 32'(cycle), 32'd0);
    tick(4'h0, 1'b0);
    checkEq("resumeCycle1", 32'(cycle), 32'd1);
`else
    checkEq("noStopAck", 32'(stopAck), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      tick(4'h0, 1'b1);
      checkEq("ignoreStopCycle", 32'(cycle), 32'(i));
      checkEq("ignoreStopAck", 32'(stopAck), 32'd0);
    end
`endif

    // Random instruction stream with random halt requests.
    for (int i = 0; i < 24; i++) begin
      runCycle(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)),
               1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    end

    checkEq("queueDrained", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/cycle_sequencer.md
# cycle_sequencer

- Machine-cycle sequencer for the TB4004 core.
- Generates the 8-phase cycle index A1–X3 consumed by the instruction decoder and ALU control.
- Latches the instruction nibbles from the ROM data bus and tracks two-word instructions.
- Optionally halts the core at instruction boundaries on request.

## Interface
Parameters: none.

Ports:
- `clk` in 1 — system clock; all state changes on rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `romData` in 4 — ROM data nibble bus, sampled at M1 and M2.
- `stopReq` in 1 — halt request; only present in behaviour with `SEQ_STOP_EN`, otherwise ignored.
- `cycle` out 3 — phase index: A1=0, A2=1, A3=2, M1=3, M2=4, X1=5, X2=6, X3=7.
- `sync` out 1 — high while `cycle`==7 (X3), marks the next A1.
- `opr` out 4 — latched opcode of the current instruction.
- `opa` out 4 — latched operand of the current instruction.
- `opr2` out 4 — latched upper nibble of the second word.
- `opa2` out 4 — latched lower nibble of the second word.
- `secondWord` out 1 — current machine cycle fetches the second word of a two-word instruction.
- `pcInc` out 1 — one-clock pulse at A3 telling the program counter to advance.
- `execValid` out 1 — high during X1..X3 of the machine cycle in which the latched instruction executes.
- `stopAck` out 1 — core is halted.

## Operation
- `cycle` counts 0→7 and wraps to 0, one step per clock while running.
- Instruction latching depends on `secondWord`:
  - `secondWord`=0: edge leaving `cycle`==3 captures `opr`←`romData`; edge leaving `cycle`==4 captures `opa`←`romData`.
  - `secondWord`=1: the same edges capture `opr2` and `opa2` instead; `opr`/`opa` hold.
- Two-word detection happens at the edge leaving `cycle`==4 in a first-word cycle, using the new opa (`romData`).
  - Internal `twoWord` is set for: opr=1 (JCN), opr=2 with opa[0]=0 (FIM), opr=4 (JUN), opr=5 (JMS), opr=7 (ISZ).
  - Any other opr clears `twoWord`.
- At the edge leaving `cycle`==7:
  - `secondWord` ← `twoWord & ~secondWord`.
  - `twoWord` clears whenever `secondWord` is already 1.
- `execValid` = `cycle`∈{5,6,7} & (`secondWord` | ~`twoWord`).
  - A two-word instruction therefore executes only in its second machine cycle.
- `pcInc` = (`cycle`==2) & running. It pulses once per machine cycle, including second-word cycles.
- `sync` = (`cycle`==7) & running.
- Reset values: `cycle`=0, `opr`=`opa`=`opr2`=`opa2`=0, `secondWord`=0, `twoWord`=0, `stopAck`=0. Hence `sync`=`pcInc`=`execValid`=0.
- Reset asserted mid-instruction discards everything, including a pending second word. After release, the next fetch is treated as a first word.

## Timing
- Machine cycle is exactly 8 clocks when running.
- `opr` is valid from `cycle`==4 onward.
- `opa` and `twoWord` are valid from `cycle`==5 (X1) onward, which is the X1 that the decoder uses for its temp load.
- `opr2`/`opa2` are valid from X1 of the second-word cycle.
- All outputs are registered or decoded from registers only; there is no combinational path from `romData` or `stopReq` to any output.

## Configuration
- Macro: `SEQ_STOP_EN`.
- Defined — two states, RUN and STOP:
  - RUN→STOP at the edge leaving `cycle`==7 when `stopReq`=1 and the next cycle is not a second word. Then `cycle`←0, `stopAck`←1.
  - A request arriving during a first-word cycle of a two-word instruction waits until that instruction completes.
  - In STOP: `cycle` holds at 0, and `pcInc`, `sync` and `execValid` are 0.
  - STOP→RUN at the first edge with `stopReq`=0. `stopAck`←0 and `cycle` stays 0 for that edge, then counting resumes.
  - `stopReq` toggling outside `cycle`==7 has no effect in RUN.
- Undefined: `stopReq` is ignored, the STOP state does not exist, and `stopAck` is tied to 0.

## Test plan
- Reset then free-run 16 clocks:
  - `cycle` goes 0..7,0..7.
  - `sync` high at clocks 7 and 15.
  - `pcInc` high at clocks 2 and 10.
- Single-word ADD: `romData`=8 at M1, 3 at M2.
  - At X1: `opr`=8, `opa`=3, `execValid`=1 for X1..X3, `secondWord` stays 0.
- JUN: words 0x4 0x2, then 0xA 0x5.
  - Cycle 1: `execValid`=0.
  - Cycle 2: `secondWord`=1, `opr`=4/`opa`=2 held, `opr2`=0xA, `opa2`=5, `execValid`=1 at X1..X3.
  - Cycle 3: `secondWord`=0.
- FIM/SRC split:
  - opr=2, opa=4 → two-word.
  - opr=2, opa=5 (SRC) → single word, `execValid`=1 in its own cycle.
- Reset mid-operation: assert `rst` at `cycle`==6 of a JMS first-word cycle.
  - All outputs reach their reset values immediately.
  - After release, the fetch `romData`=0xD,0x7 executes as a single word (`secondWord`=0).
- With `SEQ_STOP_EN`: raise `stopReq` during the first word of a JCN.
  - Halt occurs only after the second word's X3: `stopAck`=1, `cycle`=0, no `pcInc`.
  - Drop `stopReq`: `stopAck`=0 one clock later, and `cycle` reaches 1 on the following clock.
